// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Synchronises the rx pin, detects the start-bit
// falling edge, samples each bit at its centre (LSB first) and presents the
// byte with a one-cycle po_flag pulse. It rejects start glitches shorter than
// half a bit and flags a low stop bit with a one-cycle frame_err pulse.
module uart_rx #(
  parameter int UART_BPS = 9600,
  parameter int CLK      = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_CNT_MAX = CLK / UART_BPS;
  localparam int HALF         = BAUD_CNT_MAX / 2;
  // 13 bits covers the default divisor; grow if a slower clock ratio needs more.
  localparam int CNT_W        = ($clog2(BAUD_CNT_MAX) > 13) ? $clog2(BAUD_CNT_MAX) : 13;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             fall;
  logic             samp;

  // rx_s2 is the first metastability-safe copy; rx_s3 only exists for edge detection.
  assign fall = rx_s3 & ~rx_s2;
  assign samp = (state != IDLE) && (baud_cnt == CNT_SAMP);

  // Three-flop synchroniser on the asynchronous rx pin; idles high like the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Frame FSM with bit timer, shift register and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      po_data   <= '0;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      po_flag   <= 1'b0;
      frame_err <= 1'b0;

      // Free-running bit timer while a frame is active; transitions to IDLE
      // below override this so the counter is always zero in IDLE.
      if (state != IDLE) begin
        if (baud_cnt == CNT_LAST) baud_cnt <= '0;
        else                      baud_cnt <= baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (fall) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (samp) begin
            if (!rx_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Line was back high at mid start bit: a glitch, drop it silently.
              state    <= IDLE;
              busy     <= 1'b0;
              baud_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (samp) begin
            shift   <= {rx_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end

        STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (samp) begin
            state    <= IDLE;
            busy     <= 1'b0;
            baud_cnt <= '0;
            if (rx_s2) begin
              po_data <= shift;
              po_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized 8N1 frames driven into three receivers
// (16 clk/bit, 32 clk/bit for baud skew, and the default 50 MHz / 9600 build).
// Expected bytes and pulse kinds come from the frame contents themselves.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] data_a, data_b, data_c;
  logic       flag_a, flag_b, flag_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       busy_a, busy_b, busy_c;

  // 16 clk per bit
  uart_rx #(.UART_BPS(9600), .CLK(153600)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a),
    .po_data(data_a), .po_flag(flag_a), .frame_err(ferr_a), .busy(busy_a));

  // 32 clk per bit, used for the transmitter baud skew cases
  uart_rx #(.UART_BPS(9600), .CLK(307200)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b),
    .po_data(data_b), .po_flag(flag_b), .frame_err(ferr_b), .busy(busy_b));

  // default parameters
  uart_rx dut_c (
    .clk(clk), .rst(rst), .rx(rx_c),
    .po_data(data_c), .po_flag(flag_c), .frame_err(ferr_c), .busy(busy_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         inst;
    bit         err;
    logic [7:0] data;
    int         cyc;
  } evt_t;

  evt_t evq[$];
  int   both_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic evt_t mk(int inst, bit err, logic [7:0] d, int c);
    evt_t e;
    e.inst = inst;
    e.err  = err;
    e.data = d;
    e.cyc  = c;
    return e;
  endfunction

  // Record every output pulse of every receiver, sampled away from the active edge.
  always @(negedge clk) begin
    if (flag_a) evq.push_back(mk(0, 1'b0, data_a, cyc));
    if (ferr_a) evq.push_back(mk(0, 1'b1, data_a, cyc));
    if (flag_b) evq.push_back(mk(1, 1'b0, data_b, cyc));
    if (ferr_b) evq.push_back(mk(1, 1'b1, data_b, cyc));
    if (flag_c) evq.push_back(mk(2, 1'b0, data_c, cyc));
    if (ferr_c) evq.push_back(mk(2, 1'b1, data_c, cyc));
    if ((flag_a && ferr_a) || (flag_b && ferr_b) || (flag_c && ferr_c)) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of a frame {stop, data, start} LSB first, per clk per bit.
  task automatic send(input int inst, input logic [7:0] d, input int per,
                      input logic stop, input int nbits, output int t0);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < nbits; i++) begin
      set_rx(inst, fr[i]);
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic expect_evt(input string tag, input int inst, input bit err,
                            input logic [7:0] d, output int ecyc);
    evt_t e;
    ecyc = 0;
    chk({tag, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, "_inst"}, e.inst, inst);
      chk({tag, "_kind"}, e.err, err);
      chk({tag, "_data"}, e.data, d);
      ecyc = e.cyc;
    end
    evq.delete();
  endtask

  task automatic expect_none(input string tag);
    chk(tag, evq.size(), 0);
    evq.delete();
  endtask

  logic [7:0] last_a;
  int         t0, ec, bc;
  logic [7:0] rd;
  logic       rstop;

  initial begin
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    chk("reset_po_data", data_a, 8'h00);
    chk("reset_po_flag", flag_a, 1'b0);
    chk("reset_frame_err", ferr_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    rst = 1'b0;
    idle(20);
    last_a = 8'h00;

    // Single byte with latency check
    send(0, 8'hA5, 16, 1'b1, 10, t0);
    expect_evt("a5", 0, 1'b0, 8'hA5, ec);
    chk("a5_latency_window", ((ec - t0) >= 153) && ((ec - t0) <= 155), 1'b1);
    last_a = 8'hA5;
    idle(20);

    // Back-to-back: second start 1 clk after first stop bit ends
    send(0, 8'h00, 16, 1'b1, 10, t0);
    expect_evt("b2b_first", 0, 1'b0, 8'h00, ec);
    idle(1);
    send(0, 8'hFF, 16, 1'b1, 10, t0);
    expect_evt("b2b_second", 0, 1'b0, 8'hFF, ec);
    last_a = 8'hFF;
    idle(20);

    // 5 clk low glitch from idle
    bc = 0;
    set_rx(0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i == 5) set_rx(0, 1'b1);
      @(negedge clk);
      if (busy_a) bc++;
    end
    chk("glitch_busy_window", (bc >= 7) && (bc <= 10), 1'b1);
    chk("glitch_busy_low", busy_a, 1'b0);
    expect_none("glitch_no_pulse");

    // Frame error, then break, then recovery
    send(0, 8'h3C, 16, 1'b0, 10, t0);
    expect_evt("ferr", 0, 1'b1, last_a, ec);
    chk("ferr_po_data_kept", data_a, last_a);
    idle(100);
    expect_none("break_no_pulse");
    chk("break_not_busy", busy_a, 1'b0);
    set_rx(0, 1'b1);
    idle(16);
    send(0, 8'h3C, 16, 1'b1, 10, t0);
    expect_evt("recover", 0, 1'b0, 8'h3C, ec);
    last_a = 8'h3C;
    idle(10);

    // Randomized frames: good stop bit delivers the byte, low stop bit keeps the old one
    for (int k = 0; k < 10; k++) begin
      rd    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      send(0, rd, 16, rstop, 10, t0);
      if (rstop) begin
        expect_evt("rand_ok", 0, 1'b0, rd, ec);
        last_a = rd;
      end else begin
        expect_evt("rand_ferr", 0, 1'b1, last_a, ec);
      end
      set_rx(0, 1'b1);
      idle($urandom_range(2, 20));
    end

    // Reset during data bit 4 of 8'hC3
    send(0, 8'hC3, 16, 1'b1, 5, t0);
    set_rx(0, 1'b0);
    idle(8);
    rst = 1'b1;
    set_rx(0, 1'b1);
    idle(10);
    rst = 1'b0;
    idle(1);
    chk("midrst_po_data", data_a, 8'h00);
    chk("midrst_busy", busy_a, 1'b0);
    idle(40);
    expect_none("midrst_no_pulse");
    send(0, 8'h81, 16, 1'b1, 10, t0);
    expect_evt("after_rst", 0, 1'b0, 8'h81, ec);
    idle(10);

    // Transmitter baud skew of -1 and +1 clk per bit (32 clk nominal)
    send(1, 8'h5A, 31, 1'b1, 10, t0);
    expect_evt("skew_fast", 1, 1'b0, 8'h5A, ec);
    idle(40);
    send(1, 8'hA6, 33, 1'b1, 10, t0);
    expect_evt("skew_slow", 1, 1'b0, 8'hA6, ec);
    idle(40);

    // Default parameters, 5208 clk per bit
    send(2, 8'h55, 5208, 1'b1, 10, t0);
    expect_evt("default", 2, 1'b0, 8'h55, ec);
    chk("default_latency_window", ((ec - t0) >= 49476) && ((ec - t0) <= 49482), 1'b1);
    idle(20);

    chk("flag_and_err_never_together", both_cnt, 0);
    expect_none("no_stray_pulses");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
